// File: rtl/test_result_monitor.sv
// Pass/fail/timeout monitor for riscv-tests runs on the pipelined Core.
// Watches the retiring PC and gp (MODE 0) or a tohost store (MODE 1) and latches a verdict.
module test_result_monitor #(
    parameter int              XLEN        = 32,
    parameter int              MODE        = 0,
    parameter logic [XLEN-1:0] END_PC      = 'h44,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
    parameter int              SETTLE      = 2,
    parameter int              TIMEOUT     = 5000,
    parameter int              CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  gp_i,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr_i,
    input  logic [XLEN-1:0]  st_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [XLEN-2:0]  test_num_o,
    output logic [CNT_W-1:0] cycles_o
);

    typedef enum logic [1:0] {IDLE, RUN, SETTLE_ST, DONE} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(SETTLE - 1);
    localparam bit            TOHOST  = (MODE == 1);

    state_t          state;
    logic [TW-1:0]   tcnt;
    logic [SW-1:0]   scnt;

    logic            store_hit, pc_hit, pc_leave, settle_done, timeout_hit;
    logic [XLEN-1:0] verdict;
    logic            v_pass;

    // NOTE: always_comb gives every output a default first so no path leaves a latch.
    always_comb begin
        store_hit   = TOHOST && st_valid && (st_addr_i == TOHOST_ADDR) && (st_data_i != '0);
        pc_hit      = !TOHOST && pc_valid && (pc_i == END_PC);
        pc_leave    = pc_valid && (pc_i != END_PC);
        settle_done = pc_hit && (scnt >= ST_LAST);
        timeout_hit = (tcnt >= TO_LAST);
        verdict     = TOHOST ? st_data_i : gp_i;
        v_pass      = (verdict == XLEN'(1));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            scnt       <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
            test_num_o <= '0;
            cycles_o   <= '0;
        end else if (start) begin
            // Start from any state (re)enters RUN with everything cleared.
            state      <= RUN;
            tcnt       <= '0;
            scnt       <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
            test_num_o <= '0;
            cycles_o   <= '0;
        end else if (state == RUN || state == SETTLE_ST) begin
            if (cycles_o != '1)
                cycles_o <= cycles_o + CNT_W'(1);
            if (tcnt != TO_MAX)
                tcnt <= tcnt + TW'(1);

            // A verdict beats a timeout landing on the same cycle.
            if ((state == RUN && store_hit) || (state == SETTLE_ST && settle_done)) begin
                state      <= DONE;
                busy_o     <= 1'b0;
                done_o     <= 1'b1;
                pass_o     <= v_pass;
                fail_o     <= !v_pass;
                test_num_o <= v_pass ? '0 : verdict[XLEN-1:1];
            end else if (state == RUN && pc_hit) begin
                state <= SETTLE_ST;
                scnt  <= SW'(1);
            end else if (timeout_hit) begin
                state     <= DONE;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
                timeout_o <= 1'b1;
            end else if (state == SETTLE_ST && pc_leave) begin
                state <= RUN;
                scnt  <= '0;
            end else if (state == SETTLE_ST && pc_hit) begin
                scnt <= scnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor: u0 runs PC-match mode, u1 tohost-store mode, both TIMEOUT=20.
module tb_test_result_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, pc_valid, st_valid;
    logic [31:0] pc, gp, st_addr, st_data;

    logic        busy0, done0, pass0, fail0, to0;
    logic [30:0] num0;
    logic [15:0] cyc0;
    logic        busy1, done1, pass1, fail1, to1;
    logic [30:0] num1;
    logic [15:0] cyc1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    test_result_monitor #(.MODE(0), .SETTLE(2), .TIMEOUT(20)) u0 (
        .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc_i(pc), .gp_i(gp),
        .st_valid(st_valid), .st_addr_i(st_addr), .st_data_i(st_data),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .fail_o(fail0), .timeout_o(to0),
        .test_num_o(num0), .cycles_o(cyc0)
    );

    test_result_monitor #(.MODE(1), .TIMEOUT(20)) u1 (
        .clk(clk), .rst(rst), .start(start), .pc_valid(pc_valid), .pc_i(pc), .gp_i(gp),
        .st_valid(st_valid), .st_addr_i(st_addr), .st_data_i(st_data),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .fail_o(fail1), .timeout_o(to1),
        .test_num_o(num1), .cycles_o(cyc1)
    );

    typedef struct {
        logic        start;
        logic        pcv;
        logic [31:0] pc;
        logic [31:0] gp;
        logic [4:0]  flags;  // {busy, done, pass, fail, timeout}
        logic [30:0] num;
        logic [15:0] cyc;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle, then let the edge happen and settle for sampling.
    task automatic cycle(input logic s, input logic pv, input logic [31:0] p, input logic [31:0] g,
                         input logic sv, input logic [31:0] sa, input logic [31:0] sd);
        start = s; pc_valid = pv; pc = p; gp = g;
        st_valid = sv; st_addr = sa; st_data = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [4:0] flags0();
        return {busy0, done0, pass0, fail0, to0};
    endfunction

    function automatic logic [4:0] flags1();
        return {busy1, done1, pass1, fail1, to1};
    endfunction

    initial begin
        // Cases 1-3 in PC-match mode: pass, fail with a held cycle, SETTLE abort then pass.
        tbl[0]  = '{1'b1, 1'b0, 32'h00, 32'h0, 5'b10000, 31'd0, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'h44, 32'h1, 5'b10000, 31'd0, 16'd1};
        tbl[2]  = '{1'b0, 1'b1, 32'h44, 32'h1, 5'b01100, 31'd0, 16'd2};
        tbl[3]  = '{1'b0, 1'b0, 32'h00, 32'h0, 5'b01100, 31'd0, 16'd2};
        tbl[4]  = '{1'b1, 1'b0, 32'h00, 32'h0, 5'b10000, 31'd0, 16'd0};
        tbl[5]  = '{1'b0, 1'b1, 32'h44, 32'h7, 5'b10000, 31'd0, 16'd1};
        tbl[6]  = '{1'b0, 1'b0, 32'h44, 32'h7, 5'b10000, 31'd0, 16'd2};
        tbl[7]  = '{1'b0, 1'b1, 32'h44, 32'h7, 5'b01010, 31'd3, 16'd3};
        tbl[8]  = '{1'b1, 1'b0, 32'h00, 32'h0, 5'b10000, 31'd0, 16'd0};
        tbl[9]  = '{1'b0, 1'b1, 32'h44, 32'h1, 5'b10000, 31'd0, 16'd1};
        tbl[10] = '{1'b0, 1'b1, 32'h48, 32'h1, 5'b10000, 31'd0, 16'd2};
        tbl[11] = '{1'b0, 1'b1, 32'h44, 32'h1, 5'b10000, 31'd0, 16'd3};
        tbl[12] = '{1'b0, 1'b1, 32'h44, 32'h1, 5'b01100, 31'd0, 16'd4};

        rst = 1'b1;
        start = 1'b0; pc_valid = 1'b0; st_valid = 1'b0;
        pc = '0; gp = '0; st_addr = '0; st_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset u0 flags", 64'(flags0()), 64'(0));
        check("reset u0 num/cycles", 64'({num0, cyc0}), 64'(0));
        check("reset u1 flags", 64'(flags1()), 64'(0));
        rst = 1'b0;
        idle();
        check("idle u0 flags", 64'(flags0()), 64'(0));

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].start, tbl[i].pcv, tbl[i].pc, tbl[i].gp, 1'b0, 32'h0, 32'h0);
            check($sformatf("row%0d flags", i), 64'(flags0()), 64'(tbl[i].flags));
            check($sformatf("row%0d test_num", i), 64'(num0), 64'(tbl[i].num));
            check($sformatf("row%0d cycles", i), 64'(cyc0), 64'(tbl[i].cyc));
        end

        // Case 4: no match ever; timeout after exactly 20 RUN cycles in both modes.
        idle();
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 19; i++) idle();
        check("to 19 cycles u0 flags", 64'(flags0()), 64'(5'b10000));
        check("to 19 cycles u0 cycles", 64'(cyc0), 64'(19));
        idle();
        check("to 20 cycles u0 flags", 64'(flags0()), 64'(5'b01001));
        check("to 20 cycles u0 cycles", 64'(cyc0), 64'(20));
        check("to 20 cycles u1 flags", 64'(flags1()), 64'(5'b01001));
        idle();
        check("to hold u0 cycles", 64'(cyc0), 64'(20));

        // Case 5: tohost mode ignores wrong address and zero data, then fails test 5.
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1004, 32'h0B);
        check("store wrong addr ignored", 64'(flags1()), 64'(5'b10000));
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000, 32'h0);
        check("store zero ignored", 64'(flags1()), 64'(5'b10000));
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000, 32'h0B);
        check("store fail flags", 64'(flags1()), 64'(5'b01010));
        check("store fail test_num", 64'(num1), 64'(5));
        check("store fail cycles", 64'(cyc1), 64'(3));
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000, 32'h1);
        check("store pass flags", 64'(flags1()), 64'(5'b01100));
        check("store pass test_num", 64'(num1), 64'(0));

        // Case 6: async reset while in SETTLE clears outputs without waiting for an edge.
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b1, 32'h44, 32'h1, 1'b0, 32'h0, 32'h0);
        check("pre-reset busy in settle", 64'(flags0()), 64'(5'b10000));
        rst = 1'b1;
        #2;
        check("async reset u0 flags", 64'(flags0()), 64'(0));
        check("async reset u0 cycles", 64'(cyc0), 64'(0));
        check("async reset u1 flags", 64'(flags1()), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Verdict lands on the same edge the timeout would: the verdict wins.
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 18; i++) idle();
        cycle(1'b0, 1'b1, 32'h44, 32'h1, 1'b0, 32'h0, 32'h0);
        check("edge19 u0 still busy", 64'(flags0()), 64'(5'b10000));
        cycle(1'b0, 1'b1, 32'h44, 32'h1, 1'b1, 32'h1000, 32'h1);
        check("edge20 u0 pass wins", 64'(flags0()), 64'(5'b01100));
        check("edge20 u0 cycles", 64'(cyc0), 64'(20));
        check("edge20 u1 pass wins", 64'(flags1()), 64'(5'b01100));

        // gp=0 at the end PC is a fail with test number 0.
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b1, 32'h44, 32'h0, 1'b0, 32'h0, 32'h0);
        cycle(1'b0, 1'b1, 32'h44, 32'h0, 1'b0, 32'h0, 32'h0);
        check("gp zero fail flags", 64'(flags0()), 64'(5'b01010));
        check("gp zero test_num", 64'(num0), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
